clken_divider_bank: RTL

//  Multi-channel clock-enable generator running entirely in the clk_ppu domain.

---
 rtl/clken_divider_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/clken_divider_bank.sv
// Bank of runtime-divisor clock-enable channels in the clk_ppu domain, each with
// a phase count, a one-cycle enable strobe and a strobe-sequenced domain reset.

module clken_div_ch #(
    parameter int CNT_W    = 4,
    parameter int RST_HOLD = 2
) (
    input  logic             clk_ppu,
    input  logic             rst_ppu_n,
    input  logic             locked,
    input  logic             align,
    input  logic             run,
    input  logic [CNT_W-1:0] div_in,
    output logic [CNT_W-1:0] phase,
    output logic             strobe,
    output logic             rst_ch,
    output logic             div_err
);
    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
    localparam logic [HOLD_W-1:0] ONE_H    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);

    logic [CNT_W-1:0]  cnt, d;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              active, wrap;

    assign active = locked & run & (d != '0);
    assign wrap   = (cnt == d - ONE_C);
    assign strobe = rst_ppu_n & active & ~align & wrap;
    assign phase  = cnt;

    // hold counts strobes since lock and saturates at RST_HOLD
    always_comb begin
        hold_nxt = hold;
        if (strobe && (hold < HOLD_MAX))
            hold_nxt = hold + ONE_H;
    end

    always_ff @(posedge clk_ppu) begin
        if (!rst_ppu_n) begin
            cnt     <= '0;
            d       <= div_in;
            hold    <= '0;
            rst_ch  <= 1'b1;
            div_err <= 1'b0;
        end else begin
            div_err <= (d == '0);
            if (!locked) begin
                cnt    <= '0;
                hold   <= '0;
                rst_ch <= 1'b1;
            end else begin
                hold   <= hold_nxt;
                rst_ch <= (hold_nxt < HOLD_MAX);
                // a zero divisor reloads every cycle so a nonzero write restarts at phase 0
                if (align || (d == '0)) begin
                    cnt <= '0;
                    d   <= div_in;
                end else if (run) begin
                    if (wrap) begin
                        cnt <= '0;
                        d   <= div_in;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
            end
        end
    end
endmodule

module clken_divider_bank #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 4,
    parameter int RST_HOLD = 2
) (
    input  logic                    clk_ppu,
    input  logic                    rst_ppu_n,
    input  logic                    locked,
    input  logic                    align,
    input  logic [NUM_CH-1:0]       ch_run,
    input  logic [NUM_CH*CNT_W-1:0] div,
    output logic [NUM_CH*CNT_W-1:0] phase,
    output logic [NUM_CH-1:0]       strobe,
    output logic [NUM_CH-1:0]       rst_ch,
    output logic [NUM_CH-1:0]       div_err
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clken_div_ch #(
            .CNT_W    (CNT_W),
            .RST_HOLD (RST_HOLD)
        ) u_ch (
            .clk_ppu   (clk_ppu),
            .rst_ppu_n (rst_ppu_n),
            .locked    (locked),
            .align     (align),
            .run       (ch_run[i]),
            .div_in    (div[i*CNT_W +: CNT_W]),
            .phase     (phase[i*CNT_W +: CNT_W]),
            .strobe    (strobe[i]),
            .rst_ch    (rst_ch[i]),
            .div_err   (div_err[i])
        );
    end
endmodule
